lpif_rx_x2_stb_deskew: RTL

//  Receive-side aligner for the 2-channel LPIF PHY link. Sits between rx_phy0/rx_phy1 and the RX concat/unpack

---
 rtl/lpif_rx_x2_stb_deskew.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lpif_rx_x2_stb_deskew.sv
// rtl/lpif_rx_x2_stb_deskew.sv - two-channel LPIF RX strobe deskew and lock monitor
// Finds per-channel strobes, delays the early channel by the measured skew, then polices period and markers.
module lpif_rx_x2_stb_deskew #(
  parameter int CH_WIDTH   = 40,
  parameter int STB_LOC    = 1,
  parameter int MRK_LOC    = 39,
  parameter int STB_PERIOD = 8,
  parameter int MAX_SKEW   = 3,
  parameter int LOCK_CNT   = 4,
  parameter int SKW_W      = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1
) (
  input  logic                clk_rd,
  input  logic                rst_rd,
  input  logic                rx_online,
  input  logic [CH_WIDTH-1:0] rx_phy0,
  input  logic [CH_WIDTH-1:0] rx_phy1,
  output logic [CH_WIDTH-1:0] rx_phy0_algn,
  output logic [CH_WIDTH-1:0] rx_phy1_algn,
  output logic                rx_algn_vld,
  output logic                align_done,
  output logic                align_err,
  output logic [SKW_W-1:0]    skew_val,
  output logic                early_ch
);
  localparam int PER_W = $clog2(STB_PERIOD + 2);
  localparam int GD_W  = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, ALIGN, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [CH_WIDTH-1:0] dl0_q [MAX_SKEW];
  logic [CH_WIDTH-1:0] dl0_d [MAX_SKEW];
  logic [CH_WIDTH-1:0] dl1_q [MAX_SKEW];
  logic [CH_WIDTH-1:0] dl1_d [MAX_SKEW];
  logic [CH_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [SKW_W-1:0]    skew_q, skew_d, cnt_q, cnt_d;
  logic                early_q, early_d, err_q, err_d;
  logic                cnt_act_q, cnt_act_d, cand_q, cand_d;
  logic                have_prev_q, have_prev_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [GD_W-1:0]     good_q, good_d;

  logic [SKW_W-1:0]    tap0, tap1;
  logic [CH_WIDTH-1:0] a0, a1;
  logic                s0r, s1r, s0a, s1a, bad;

  // Taps follow skew_q only once aligning, so SEARCH always sees undelayed words.
  always_comb begin
    tap0 = '0;
    tap1 = '0;
    if (state_q == ALIGN || state_q == LOCKED) begin
      if (early_q) tap1 = skew_q;
      else         tap0 = skew_q;
    end
    a0 = rx_phy0;
    a1 = rx_phy1;
    for (int i = 1; i <= MAX_SKEW; i++) begin
      if (tap0 == SKW_W'(i)) a0 = dl0_q[i-1];
      if (tap1 == SKW_W'(i)) a1 = dl1_q[i-1];
    end
    dl0_d[0] = rx_phy0;
    dl1_d[0] = rx_phy1;
    for (int i = 1; i < MAX_SKEW; i++) begin
      dl0_d[i] = dl0_q[i-1];
      dl1_d[i] = dl1_q[i-1];
    end
    out0_d = a0;
    out1_d = a1;
  end

  always_comb begin
    s0r = rx_phy0[STB_LOC];
    s1r = rx_phy1[STB_LOC];
    s0a = a0[STB_LOC];
    s1a = a1[STB_LOC];
    state_d     = state_q;
    err_d       = 1'b0;
    skew_d      = skew_q;
    early_d     = early_q;
    cnt_d       = cnt_q;
    cnt_act_d   = cnt_act_q;
    cand_d      = cand_q;
    have_prev_d = have_prev_q;
    good_d      = good_q;
    bad         = 1'b0;
    per_d       = per_q;
    if (per_q != PER_W'(STB_PERIOD + 1)) per_d = per_q + 1'b1;
    if (s0a && s1a) per_d = PER_W'(1);
    case (state_q)
      IDLE: begin
        cnt_act_d = 1'b0;
        if (rx_online) state_d = SEARCH;
      end
      SEARCH: begin
        if (!cnt_act_q) begin
          if (s0r && s1r) begin
            skew_d  = '0;
            early_d = 1'b0;
            state_d = ALIGN;
          end else if (s0r || s1r) begin
            cnt_act_d = 1'b1;
            cand_d    = s1r;
            cnt_d     = SKW_W'(1);
          end
        end else if (cand_q ? s0r : s1r) begin
          skew_d    = cnt_q;
          early_d   = cand_q;
          cnt_act_d = 1'b0;
          state_d   = ALIGN;
        end else if (cnt_q == SKW_W'(MAX_SKEW)) begin
          err_d     = 1'b1;
          cnt_act_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        per_d       = '0;
        have_prev_d = 1'b0;
        good_d      = '0;
      end
      default: begin
        // The first aligned strobe after SEARCH has no reference, so only coincidence is required.
        if (s0a != s1a) begin
          bad = 1'b1;
        end else if (s0a) begin
          if (have_prev_q && per_q != PER_W'(STB_PERIOD)) bad = 1'b1;
          else begin
            have_prev_d = 1'b1;
            if (state_q == ALIGN) good_d = good_q + 1'b1;
          end
        end else if (have_prev_q && per_q == PER_W'(STB_PERIOD + 1)) begin
          bad = 1'b1;
        end
        if (state_q == LOCKED && a0[MRK_LOC] != a1[MRK_LOC]) bad = 1'b1;
        if (bad) begin
          err_d     = 1'b1;
          cnt_act_d = 1'b0;
          state_d   = SEARCH;
        end else if (state_q == ALIGN && good_d == GD_W'(LOCK_CNT)) begin
          state_d = LOCKED;
        end
      end
    endcase
    if (!rx_online) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      state_q     <= IDLE;
      for (int i = 0; i < MAX_SKEW; i++) begin
        dl0_q[i] <= '0;
        dl1_q[i] <= '0;
      end
      out0_q      <= '0;
      out1_q      <= '0;
      skew_q      <= '0;
      cnt_q       <= '0;
      early_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_act_q   <= 1'b0;
      cand_q      <= 1'b0;
      have_prev_q <= 1'b0;
      per_q       <= '0;
      good_q      <= '0;
    end else begin
      state_q     <= state_d;
      dl0_q       <= dl0_d;
      dl1_q       <= dl1_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      skew_q      <= skew_d;
      cnt_q       <= cnt_d;
      early_q     <= early_d;
      err_q       <= err_d;
      cnt_act_q   <= cnt_act_d;
      cand_q      <= cand_d;
      have_prev_q <= have_prev_d;
      per_q       <= per_d;
      good_q      <= good_d;
    end
  end

  assign rx_phy0_algn = out0_q;
  assign rx_phy1_algn = out1_q;
  assign rx_algn_vld  = (state_q == LOCKED);
  assign align_done   = (state_q == LOCKED);
  assign align_err    = err_q;
  assign skew_val     = skew_q;
  assign early_ch     = early_q;

endmodule
